// File: rtl/adaptive_binarize.sv
// Adaptive-threshold binariser with causal 3-tap horizontal majority filter.
// Threshold is the previous frame's centre-window mean minus an offset.
module adaptive_binarize #(
  parameter int OFFSET      = 32,
  parameter int INIT_THRESH = 512,
  parameter int FW          = 640,
  parameter int FH          = 480,
  parameter int WX0         = 192,
  parameter int WY0         = 112,
  parameter int WL          = 8
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iDVAL,
  input  logic [9:0] iDATA,
  output logic       oDVAL,
  output logic [9:0] oDATA,
  output logic [9:0] oTHRESH,
  output logic       oFDONE
);

  localparam int XW = $clog2(FW);
  localparam int YW = $clog2(FH);
  localparam int SW = 10 + 2 * WL;
  localparam int WS = 1 << WL;

  localparam logic [XW-1:0] X_LAST = XW'(FW - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(FH - 1);
  localparam logic [XW-1:0] X_W0   = XW'(WX0);
  localparam logic [XW-1:0] X_W1   = XW'(WX0 + WS - 1);
  localparam logic [YW-1:0] Y_W0   = YW'(WY0);
  localparam logic [YW-1:0] Y_W1   = YW'(WY0 + WS - 1);
  localparam logic [9:0]    OFF    = 10'(OFFSET);
  localparam logic [9:0]    THR0   = 10'(INIT_THRESH);

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [SW-1:0] r_sum;
  logic [9:0]    r_thresh;
  logic          r_fdone;
  logic          r_va;
  logic          r_da;
  logic [XW-1:0] r_xa;
  logic          r_h1;
  logic          r_h2;
  logic          r_dval;
  logic [9:0]    r_data;

  logic          w_last;
  logic          w_inwin;
  logic [SW-1:0] w_sum;
  logic [9:0]    w_mean;
  logic          w_dark;
  logic          w_maj;

  assign w_last  = (r_x == X_LAST) && (r_y == Y_LAST);
  assign w_inwin = (r_x >= X_W0) && (r_x <= X_W1) &&
                   (r_y >= Y_W0) && (r_y <= Y_W1);
  assign w_sum   = r_sum +
                   (w_inwin ? {{(SW-10){1'b0}}, iDATA} : '0);
  assign w_mean  = w_sum[SW-1 -: 10];
  assign w_dark  = iDATA < r_thresh;

  // raster position of the pixel being accepted
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_x <= '0;
      r_y <= '0;
    end else if (iDVAL) begin
      if (w_last) begin
        r_x <= '0;
        r_y <= '0;
      end else if (r_x == X_LAST) begin
        r_x <= '0;
        r_y <= r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  // window accumulation and per-frame threshold update
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_sum    <= '0;
      r_thresh <= THR0;
      r_fdone  <= 1'b0;
    end else begin
      r_fdone <= 1'b0;
      if (iDVAL) begin
        if (w_last) begin
          r_sum    <= '0;
          r_thresh <= (w_mean > OFF) ? w_mean - OFF : '0;
          r_fdone  <= 1'b1;
        end else begin
          r_sum <= w_sum;
        end
      end
    end
  end

  // stage A: threshold compare against the current threshold
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_va <= 1'b0;
      r_da <= 1'b0;
      r_xa <= '0;
    end else begin
      r_va <= iDVAL;
      if (iDVAL) begin
        r_da <= w_dark;
        r_xa <= r_x;
      end
    end
  end

  // majority vote; row start has no left neighbours
  always_comb begin
    w_maj = 1'b0;
    unique case (1'b1)
      (r_xa == '0):     w_maj = r_da;
      (r_xa == XW'(1)): w_maj = r_h1;
      default: w_maj = (r_da & r_h1) | (r_da & r_h2) |
                       (r_h1 & r_h2);
    endcase
  end

  // stage B: filter history and output register
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_dval <= 1'b0;
      r_data <= '0;
      r_h1   <= 1'b0;
      r_h2   <= 1'b0;
    end else begin
      r_dval <= r_va;
      if (r_va) begin
        r_data <= w_maj ? 10'h000 : 10'h3FF;
        if (r_xa == '0) begin
          r_h1 <= r_da;
          r_h2 <= r_da;
        end else begin
          r_h2 <= r_h1;
          r_h1 <= r_da;
        end
      end
    end
  end

  assign oDVAL   = r_dval;
  assign oDATA   = r_data;
  assign oTHRESH = r_thresh;
  assign oFDONE  = r_fdone;

endmodule
